// File: rtl/usb_tx_pkt_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_tx_pkt_if                                                   |
// | Purpose  : Bundles the request, payload-buffer and PHY byte-stream signals  |
// |            of the USB packet transmitter.                                   |
// | Ports    : start/send_data/handshake/toggle/data_len - packet request       |
// |            rd_addr/rd_data  - asynchronous payload buffer read              |
// |            tx_data/tx_valid/tx_ready/tx_last - byte stream to the PHY       |
// |            busy/done        - packet status                                 |
// | Modports : slave = transmitter, master = packet source / PHY side           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface usb_tx_pkt_if;
   logic       start;
   logic       send_data;
   logic [1:0] handshake;
   logic       toggle;
   logic [6:0] data_len;
   logic [5:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_last;
   logic       busy;
   logic       done;

   modport slave (
      input  start, send_data, handshake, toggle, data_len, rd_data, tx_ready,
      output rd_addr, tx_data, tx_valid, tx_last, busy, done
   );

   modport master (
      output start, send_data, handshake, toggle, data_len, rd_data, tx_ready,
      input  rd_addr, tx_data, tx_valid, tx_last, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/usb_tx_pkt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_tx_pkt                                                      |
// | Purpose  : Serialises a USB handshake or DATA0/DATA1 packet into bytes for  |
// |            the PHY: PID, payload (read from an external buffer), CRC16.     |
// | Ports    : clk_i-less naming kept as clk / rst_n (async, active low)        |
// |            bus - usb_tx_pkt_if.slave (request, buffer read, byte stream)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module usb_tx_pkt (
   input  logic          clk,
   input  logic          rst_n,
   usb_tx_pkt_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PID    = 3'd1,
      S_DATA   = 3'd2,
      S_CRC_LO = 3'd3,
      S_CRC_HI = 3'd4,
      S_FIN    = 3'd5
   } state_e;

   localparam logic [1:0]  HS_NONE   = 2'b01;
   localparam logic [6:0]  MAX_LEN   = 7'd64;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   state_e      state_q, state_d;
   logic        send_data_q, send_data_d;
   logic [1:0]  hs_q, hs_d;
   logic        toggle_q, toggle_d;
   logic [6:0]  len_q, len_d;
   logic [5:0]  idx_q, idx_d;
   logic [15:0] crc_q, crc_d;

   logic [3:0]  pid;
   logic [6:0]  last_idx;
   logic        accept;
   logic        tx_valid, tx_last, done;
   logic [7:0]  tx_data;
   logic [5:0]  rd_addr;

   // Reflected CRC16 (poly A001h), one byte consumed LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // Handshake code 01 never reaches PID, so it shares the default arm.
   always_comb begin
      pid = 4'b0010;
      if (send_data_q) begin
         pid = toggle_q ? 4'b1011 : 4'b0011;
      end else begin
         case (hs_q)
            2'b00:   pid = 4'b0010;
            2'b10:   pid = 4'b1010;
            default: pid = 4'b1110;
         endcase
      end
   end

   // len_q is at least 1 whenever DATA is entered.
   assign last_idx = len_q - 7'd1;
   assign accept   = tx_valid & bus.tx_ready;

   always_comb begin
      state_d     = state_q;
      send_data_d = send_data_q;
      hs_d        = hs_q;
      toggle_d    = toggle_q;
      len_d       = len_q;
      idx_d       = idx_q;
      crc_d       = crc_q;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      tx_data     = 8'h00;
      rd_addr     = 6'd0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               send_data_d = bus.send_data;
               hs_d        = bus.handshake;
               toggle_d    = bus.toggle;
               len_d       = (bus.data_len > MAX_LEN) ? MAX_LEN : bus.data_len;
               idx_d       = 6'd0;
               crc_d       = CRC_INIT;
               state_d     = (!bus.send_data && bus.handshake == HS_NONE) ? S_FIN : S_PID;
            end
         end
         S_PID: begin
            tx_valid = 1'b1;
            tx_data  = {~pid, pid};
            tx_last  = ~send_data_q;
            if (accept) begin
               if (!send_data_q)        state_d = S_FIN;
               else if (len_q == 7'd0)  state_d = S_CRC_LO;
               else                     state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = bus.rd_data;
            rd_addr  = idx_q;
            if (accept) begin
               crc_d = crc16_byte(crc_q, bus.rd_data);
               // Leave on the last index so a 64-byte payload never wraps to 0.
               if ({1'b0, idx_q} == last_idx) begin
                  idx_d   = 6'd0;
                  state_d = S_CRC_LO;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         S_CRC_LO: begin
            tx_valid = 1'b1;
            tx_data  = ~crc_q[7:0];
            if (accept) state_d = S_CRC_HI;
         end
         S_CRC_HI: begin
            tx_valid = 1'b1;
            tx_data  = ~crc_q[15:8];
            tx_last  = 1'b1;
            if (accept) state_d = S_FIN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         send_data_q <= 1'b0;
         hs_q        <= 2'b00;
         toggle_q    <= 1'b0;
         len_q       <= 7'd0;
         idx_q       <= 6'd0;
         crc_q       <= CRC_INIT;
      end else begin
         state_q     <= state_d;
         send_data_q <= send_data_d;
         hs_q        <= hs_d;
         toggle_q    <= toggle_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         crc_q       <= crc_d;
      end
   end

   assign bus.tx_valid = tx_valid;
   assign bus.tx_last  = tx_last;
   assign bus.tx_data  = tx_data;
   assign bus.rd_addr  = rd_addr;
   assign bus.done     = done;
   assign bus.busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_pkt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_usb_tx_pkt                                                   |
// | Purpose  : Scoreboard bench for usb_tx_pkt with a queue-based packet model  |
// |            and a free-running monitor on the byte stream and done pulse.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_usb_tx_pkt;

   logic clk;
   logic rst_n;
   int   rmode;          // 0: ready high, 1: toggle, 2: random
   int   checks;
   int   errors;
   int   done_pending;
   logic [8:0] exp_q[$];  // {last, data}
   logic [7:0] mem[64];

   usb_tx_pkt_if bus();

   usb_tx_pkt dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.rd_data = mem[bus.rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       bus.tx_ready = 1'b1;
         1:       bus.tx_ready = ~bus.tx_ready;
         default: bus.tx_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Bit-serial CRC16 over the payload as a LSB-first bit stream.
   function automatic logic [15:0] ref_crc(input int n);
      logic        bits[$];
      logic [15:0] r;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++) bits.push_back(mem[i][b]);
      r = 16'hFFFF;
      foreach (bits[k]) begin
         if (r[0] != bits[k]) r = (r >> 1) ^ 16'hA001;
         else                 r = r >> 1;
      end
      return r;
   endfunction

   task automatic build_expected(input logic sd, input logic [1:0] hs, input logic tg,
                                 input logic [6:0] len, output int nexp);
      int          n;
      logic [15:0] c;
      nexp = 0;
      if (!sd) begin
         case (hs)
            2'b00: begin exp_q.push_back({1'b1, 8'hD2}); nexp = 1; end
            2'b10: begin exp_q.push_back({1'b1, 8'h5A}); nexp = 1; end
            2'b11: begin exp_q.push_back({1'b1, 8'h1E}); nexp = 1; end
            default: nexp = 0;
         endcase
      end else begin
         n = (int'(len) > 64) ? 64 : int'(len);
         exp_q.push_back({1'b0, tg ? 8'h4B : 8'hC3});
         for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mem[i]});
         c = ~ref_crc(n);
         exp_q.push_back({1'b0, c[7:0]});
         exp_q.push_back({1'b1, c[15:8]});
         nexp = n + 3;
      end
      done_pending++;
   endtask

   task automatic wait_idle;
      int g;
      g = 0;
      while (bus.busy && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 3000) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_pkt(input logic sd, input logic [1:0] hs, input logic tg,
                           input logic [6:0] len, input bit rnd_mem);
      int nexp, vcyc, bcyc, g;
      wait_idle();
      if (rnd_mem) foreach (mem[i]) mem[i] = 8'($urandom);
      build_expected(sd, hs, tg, len, nexp);
      bus.start     = 1'b1;
      bus.send_data = sd;
      bus.handshake = hs;
      bus.toggle    = tg;
      bus.data_len  = len;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (nexp > 0) chk("first_byte_latency", 32'(bus.tx_valid), 32'd1);
      else          chk("hs_none_done", 32'(bus.done), 32'd1);
      vcyc = 0; bcyc = 0; g = 0;
      while (bus.busy && g < 3000) begin
         bcyc++;
         if (bus.tx_valid) vcyc++;
         // Stray requests while busy (including FIN) must be ignored.
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.send_data = 1'($urandom);
         bus.handshake = 2'($urandom);
         bus.data_len  = 7'($urandom);
         @(posedge clk); #1;
         g++;
      end
      bus.start = 1'b0;
      if (g >= 3000) chk("pkt_timeout", 32'd1, 32'd0);
      if (rmode == 0) begin
         chk("valid_cycles", 32'(vcyc), 32'(nexp));
         chk("busy_cycles",  32'(bcyc), 32'(nexp + 1));
      end
   endtask

   // Monitor: pops the scoreboard on every accepted byte and on done.
   logic       held_v;
   logic [8:0] held;
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v && bus.tx_valid)
            chk("hold_stable", 32'({bus.tx_last, bus.tx_data}), 32'(held));
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'({bus.tx_last, bus.tx_data}), 32'h1FF);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", 32'({bus.tx_last, bus.tx_data}), 32'(e));
            end
         end
         if (bus.done) begin
            chk("done_expected", 32'(done_pending > 0), 32'd1);
            chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
            if (done_pending > 0) done_pending--;
         end
         held_v = bus.tx_valid && !bus.tx_ready;
         held   = {bus.tx_last, bus.tx_data};
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nexp;
      checks = 0; errors = 0; done_pending = 0; rmode = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.send_data = 1'b0; bus.handshake = 2'b00;
      bus.toggle = 1'b0; bus.data_len = 7'd0; bus.tx_ready = 1'b0;
      foreach (mem[i]) mem[i] = 8'h00;
      @(posedge clk); #1;
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_last",  32'(bus.tx_last),  32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
      chk("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Handshakes, zero-length DATA1, no-handshake
      send_pkt(1'b0, 2'b00, 1'b0, 7'd0, 1'b1);
      send_pkt(1'b0, 2'b10, 1'b0, 7'd0, 1'b1);
      send_pkt(1'b0, 2'b11, 1'b0, 7'd0, 1'b1);
      send_pkt(1'b1, 2'b00, 1'b1, 7'd0, 1'b1);
      send_pkt(1'b0, 2'b01, 1'b0, 7'd0, 1'b1);

      // DATA0 01 02 03 with tx_ready toggling
      wait_idle();
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
      rmode = 1;
      send_pkt(1'b1, 2'b00, 1'b0, 7'd3, 1'b0);

      // Over-length and exactly-64 payloads
      rmode = 0;
      send_pkt(1'b1, 2'b00, 1'b1, 7'd70, 1'b1);
      send_pkt(1'b1, 2'b00, 1'b0, 7'd64, 1'b1);
      send_pkt(1'b1, 2'b00, 1'b0, 7'd1, 1'b1);

      // Reset during the first payload byte
      wait_idle();
      foreach (mem[i]) mem[i] = 8'($urandom);
      build_expected(1'b1, 2'b00, 1'b0, 7'd10, nexp);
      bus.start = 1'b1; bus.send_data = 1'b1; bus.toggle = 1'b0; bus.data_len = 7'd10;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("async_rst_busy",  32'(bus.busy),     32'd0);
      chk("async_rst_addr",  32'(bus.rd_addr),  32'd0);
      exp_q.delete();
      done_pending = 0;
      @(posedge clk); #1;
      chk("rst_hold_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_pkt(1'b1, 2'b00, 1'b1, 7'd5, 1'b1);

      // Randomised packets with random back-pressure
      for (int k = 0; k < 40; k++) begin
         rmode = ($urandom_range(0, 3) == 0) ? 0 : 2;
         send_pkt(1'($urandom), 2'($urandom), 1'($urandom), 7'($urandom_range(0, 80)), 1'b1);
      end

      wait_idle();
      @(posedge clk); #1;
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_done_pending", 32'(done_pending), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb_tx_pkt.md
USB_TX_PKT -- requirements
Module: usb_tx_pkt

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock is clk, reset is rst_n.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-005 send_data  in  1  1 = DATA packet, 0 = handshake packet.
REQ-006 handshake  in  2  hs_ack=00, hs_none=01, hs_nak=10, hs_stall=11; used when send_data=0.
REQ-007 toggle  in  1  0 = DATA0, 1 = DATA1; used when send_data=1.
REQ-008 data_len  in  7  payload byte count, 0..64.
REQ-009 rd_addr  out  6  payload buffer index, combinational from state.
REQ-010 rd_data  in  8  payload byte at rd_addr; asynchronous read.
REQ-011 tx_data  out  8  byte to PHY/bit-stuffer, LSB sent first.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  PHY accepts byte when tx_valid && tx_ready.
REQ-014 tx_last  out  1  marks final byte of packet; qualified by tx_valid.
REQ-015 busy  out  1  high from the cycle after accepted start until done.
REQ-016 done  out  1  one-cycle pulse at packet end.

Function
REQ-017 SHALL implement states IDLE, PID, DATA, CRC_LO, CRC_HI, FIN.
REQ-018 In IDLE with start=1, SHALL register send_data, handshake, toggle and min(data_len,64), then enter PID next cycle; start outside IDLE SHALL be ignored.
REQ-019 start with send_data=0 and handshake=hs_none SHALL go directly to FIN, emit no byte, and pulse done.
REQ-020 PID byte SHALL be {~pid[3:0], pid[3:0]}: ACK D2h, NAK 5Ah, STALL 1Eh, DATA0 C3h, DATA1 4Bh.
REQ-021 Handshake packet: PID byte only, tx_last=1.
REQ-022 DATA packet: PID, then data_len payload bytes (rd_addr 0..len-1, tx_data=rd_data), then CRC low byte, then CRC high byte with tx_last=1.
REQ-023 data_len=0 SHALL go PID -> CRC_LO directly.
REQ-024 CRC16: reflected polynomial A001h (8005h), init FFFFh, updated per accepted payload byte LSB-first; transmitted value SHALL be bitwise complement, low byte first.
REQ-025 CRC SHALL be reinitialised to FFFFh on every accepted start.
REQ-026 tx_valid SHALL be high in PID, DATA, CRC_LO, CRC_HI; low in IDLE and FIN.
REQ-027 State and rd_addr SHALL advance only on a cycle with tx_valid && tx_ready; tx_data, tx_last SHALL hold stable while tx_ready=0.
REQ-028 rd_addr SHALL be 0 outside DATA; in DATA it SHALL equal the payload byte index; a 64-byte payload ends at index 63 with no 6-bit wrap emitted.
REQ-029 FIN SHALL last exactly one cycle, assert done, and return to IDLE; a start in that cycle SHALL be ignored.
REQ-030 Latency: first byte presented with tx_valid=1 on the cycle after start; with tx_ready held high an N-byte DATA packet SHALL complete in N+3 cycles of tx_valid.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, mid-packet included, abandoning the packet with no done pulse.
REQ-032 Reset values: tx_valid=0, tx_last=0, tx_data=00h, rd_addr=0, busy=0, done=0, CRC=FFFFh.

Verification
REQ-033 start, send_data=0, handshake=00, tx_ready=1 -> one byte D2h with tx_last=1, done the next cycle.
REQ-034 start, send_data=1, toggle=1, data_len=0 -> bytes 4Bh, 00h, 00h; tx_last only on third; done after.
REQ-035 start, handshake=01, send_data=0 -> no tx_valid, done pulse, busy one cycle.
REQ-036 DATA0, data_len=3, buffer 01h 02h 03h, tx_ready toggled 1/0 each cycle -> C3h 01h 02h 03h CRC_LO CRC_HI, each held while tx_ready=0, CRC matching bit-serial model.
REQ-037 DATA1, data_len=70 -> exactly 64 payload bytes, rd_addr 0..63.
REQ-038 rst_n pulsed low during byte 2 of a DATA packet -> tx_valid=0 asynchronously, no done; next start sends fresh PID with CRC reinitialised.
